forth_stack: RTL and testbench
==============================

# forth_stack

Parametrised hardware stack for the nybbleForth CPU family. It replaces the fixed 16×16 data and return stack arrays with one reusable block. A registered top-of-stack (T) and a memory array hold the remaining entries. It provides depth tracking, full/empty status, Forth stack-manipulation ops and optional overflow/underflow guarding. The CPU instantiates two copies: one data stack and one return stack.

## Interface
- WIDTH, 16: cell width in bits
- DEPTH, 16: total capacity in cells, including T; must be a power of two and at least 4
- AW, $clog2(DEPTH): array pointer width
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- op_valid  input  1  executes `op` on this clock edge when high
- op  input  3  0 NOP, 1 PUSH, 2 POP, 3 DUP, 4 SWAP, 5 OVER, 6 BINOP, 7 REPLACE
- din  input  WIDTH  operand for PUSH, BINOP and REPLACE
- tos  output  WIDTH  T register
- nos  output  WIDTH  second cell; 0 when depth < 2
- depth  output  AW+1  cell count, 0..DEPTH
- empty  output  1  depth == 0
- full  output  1  depth == DEPTH
- error  output  1  sticky overflow/underflow flag

## Operation
- Storage:
  - T register holds the top cell.
  - Array `mem[0..DEPTH-1]` holds cells below T.
  - Pointer `sp` (AW bits) addresses the second cell.
  - `nos = mem[sp]` combinationally, gated to 0 when depth < 2.
- Ops, with old values T, N and depth d:
  - PUSH: `mem[sp+1] <= T`, `sp <= sp+1`, `T <= din`, `d+1`
  - POP: `T <= N`, `sp <= sp-1`, `d-1`; when d == 1, `T <= 0`
  - DUP: `mem[sp+1] <= T`, `sp <= sp+1`, `d+1`
  - SWAP: `mem[sp] <= T`, `T <= N`; d unchanged
  - OVER: `mem[sp+1] <= T`, `sp <= sp+1`, `T <= N`, `d+1`
  - BINOP: `T <= din`, `sp <= sp-1`, `d-1`. The caller computes `din = f(N, T)` combinationally from `nos`/`tos`.
  - REPLACE: `T <= din`; d unchanged
  - NOP, or op_valid low: no state change
- Pointer arithmetic is modulo DEPTH. The depth counter is AW+1 bits.
- Array writes are synchronous, one port, one write per cycle. Reads are asynchronous.
- Reset:
  - Outputs: tos = 0, depth = 0, sp = DEPTH-1, empty = 1, full = 0, error = 0, nos = 0.
  - Array contents are not cleared.
  - Reset overrides op_valid in the same cycle.
  - Reset mid-sequence discards all cells.

## Timing
- Every op completes in one cycle. All outputs reflect the new state immediately after the edge that sampled op_valid.
- No stall and no ready signal: the block accepts an op every cycle.
- nos follows sp and the array with zero-cycle combinational latency after the edge.
- empty and full are registered, or decoded from the registered depth; they are valid the same cycle as depth.
- error rises on the edge that samples the illegal op and stays high until reset.

## Configuration
- Macro: `FORTH_STACK_GUARD_EN`.
- Defined:
  - Illegal ops are suppressed (no state change) and set error.
  - Overflow: PUSH, DUP or OVER when full.
  - Underflow:
    - POP, DUP or REPLACE when d == 0
    - SWAP, OVER or BINOP when d < 2
- Undefined:
  - The error output is tied to 0.
  - Every op executes unconditionally.
  - sp wraps modulo DEPTH.
  - depth saturates at DEPTH on increment and at 0 on decrement.
  - An overflowing push overwrites the oldest cell, giving circular-stack behaviour like the original fixed 4-bit pointers.

## Test plan
- Reset, then PUSH 0x1111, 0x2222, 0x3333 → tos = 0x3333, nos = 0x2222, depth = 3, empty = 0.
- From that state: SWAP → tos = 0x2222, nos = 0x3333. OVER → tos = 0x3333, depth = 4. POP ×4 → empty = 1, tos = 0.
- PUSH 5, PUSH 7, then BINOP with din = nos + tos → tos = 12, depth = 1, nos = 0.
- DEPTH = 4: push 4 cells, then a 5th PUSH.
  - Guard on: depth = 4, full = 1, tos unchanged, error = 1.
  - Guard off: depth = 4, error = 0, tos = new value, oldest cell lost.
- POP on an empty stack with guard on → error = 1, depth = 0. Then assert reset → error = 0.
- Assert reset in the same cycle as PUSH 0xBEEF at depth 2 → depth = 0, tos = 0; op ignored.

Source files
------------

// File: rtl/forth_stack.sv
// Parametrised Forth stack: registered top-of-stack plus an asynchronous-read cell array.
// Define FORTH_STACK_GUARD_EN to suppress overflow/underflow ops and raise a sticky error flag.
module forth_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [AW:0]      depth,
  output logic             empty,
  output logic             full,
  output logic             error
);

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_PUSH    = 3'd1;
  localparam logic [2:0] OP_POP     = 3'd2;
  localparam logic [2:0] OP_DUP     = 3'd3;
  localparam logic [2:0] OP_SWAP    = 3'd4;
  localparam logic [2:0] OP_OVER    = 3'd5;
  localparam logic [2:0] OP_BINOP   = 3'd6;
  localparam logic [2:0] OP_REPLACE = 3'd7;

  localparam logic [AW:0] D_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_tos;
  logic [AW-1:0]    r_sp;
  logic [AW:0]      r_depth;

  logic [AW-1:0]    w_sp_inc;
  logic [AW-1:0]    w_sp_dec;
  logic             w_ge1;
  logic             w_ge2;
  logic [WIDTH-1:0] w_n;
  logic             w_exec;
  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [WIDTH-1:0] w_wdata;

  function automatic logic [AW:0] sat_inc(input logic [AW:0] d);
    return (d == D_FULL) ? d : d + 1'b1;
  endfunction

  function automatic logic [AW:0] sat_dec(input logic [AW:0] d);
    return (d == '0) ? d : d - 1'b1;
  endfunction

  assign w_sp_inc = r_sp + 1'b1;
  assign w_sp_dec = r_sp - 1'b1;
  assign w_ge1    = (r_depth != '0);
  assign w_ge2    = (r_depth > (AW+1)'(1));
  assign w_n      = w_ge2 ? r_mem[r_sp] : '0;

`ifdef FORTH_STACK_GUARD_EN
  logic w_ovf;
  logic w_unf;
  logic r_error;

  always_comb begin
    w_ovf = 1'b0;
    w_unf = 1'b0;
    case (op)
      OP_PUSH:    w_ovf = (r_depth == D_FULL);
      OP_DUP:     begin w_ovf = (r_depth == D_FULL); w_unf = !w_ge1; end
      OP_OVER:    begin w_ovf = (r_depth == D_FULL); w_unf = !w_ge2; end
      OP_POP:     w_unf = !w_ge1;
      OP_REPLACE: w_unf = !w_ge1;
      OP_SWAP:    w_unf = !w_ge2;
      OP_BINOP:   w_unf = !w_ge2;
      default:    ;
    endcase
  end

  assign w_exec = op_valid && !(w_ovf || w_unf);

  always_ff @(posedge clock) begin
    if (reset)
      r_error <= 1'b0;
    else if (op_valid && (w_ovf || w_unf))
      r_error <= 1'b1;
  end

  assign error = r_error;
`else
  assign w_exec = op_valid;
  assign error  = 1'b0;
`endif

  // Single write port: pushes land above the current second cell, SWAP rewrites it in place.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = w_sp_inc;
    w_wdata = r_tos;
    if (w_exec && !reset) begin
      case (op)
        OP_PUSH, OP_DUP, OP_OVER: w_we = 1'b1;
        OP_SWAP: begin
          w_we    = 1'b1;
          w_waddr = r_sp;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_we)
      r_mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_tos   <= '0;
      r_sp    <= AW'(DEPTH - 1);
      r_depth <= '0;
    end else if (w_exec) begin
      case (op)
        OP_PUSH: begin
          r_sp    <= w_sp_inc;
          r_tos   <= din;
          r_depth <= sat_inc(r_depth);
        end
        OP_POP: begin
          r_sp    <= w_sp_dec;
          r_tos   <= w_n;
          r_depth <= sat_dec(r_depth);
        end
        OP_DUP: begin
          r_sp    <= w_sp_inc;
          r_depth <= sat_inc(r_depth);
        end
        OP_SWAP: r_tos <= w_n;
        OP_OVER: begin
          r_sp    <= w_sp_inc;
          r_tos   <= w_n;
          r_depth <= sat_inc(r_depth);
        end
        OP_BINOP: begin
          r_sp    <= w_sp_dec;
          r_tos   <= din;
          r_depth <= sat_dec(r_depth);
        end
        OP_REPLACE: r_tos <= din;
        default: ;
      endcase
    end
  end

  assign tos   = r_tos;
  assign nos   = w_n;
  assign depth = r_depth;
  assign empty = (r_depth == '0);
  assign full  = (r_depth == D_FULL);

endmodule

// File: tb/tb_forth_stack.sv
// Scoreboard bench for forth_stack (DEPTH=4) against a queue-based stack model.
// Honours FORTH_STACK_GUARD_EN the same way as the design.
module tb_forth_stack;
  localparam int W  = 16;
  localparam int D  = 4;
  localparam int AW = $clog2(D);

  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, DUP = 3'd3,
                         SWAP = 3'd4, OVER = 3'd5, BINOP = 3'd6, REPL = 3'd7;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          op_valid = 1'b0;
  logic [2:0]    op = 3'd0;
  logic [W-1:0]  din = '0;
  logic [W-1:0]  tos, nos;
  logic [AW:0]   depth;
  logic          empty, full, error;

  forth_stack #(.WIDTH(W), .DEPTH(D)) u_dut (
    .clock(clock), .reset(reset), .op_valid(op_valid), .op(op), .din(din),
    .tos(tos), .nos(nos), .depth(depth), .empty(empty), .full(full), .error(error)
  );

  always #5 clock = ~clock;

  typedef struct {
    string        nm;
    logic [W-1:0] tos;
    logic [W-1:0] nos;
    int           depth;
    logic         empty;
    logic         full;
    logic         error;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] stk[$];
  bit           merr;
  int           checks = 0;
  int           failures = 0;

  function automatic logic [W-1:0] m_t();
    return (stk.size() > 0) ? stk[stk.size()-1] : '0;
  endfunction

  function automatic logic [W-1:0] m_n();
    return (stk.size() > 1) ? stk[stk.size()-2] : '0;
  endfunction

  function automatic bit underflow(input logic [2:0] o, input int sz);
    return ((o == POP || o == DUP || o == REPL) && sz == 0) ||
           ((o == SWAP || o == OVER || o == BINOP) && sz < 2);
  endfunction

`ifdef FORTH_STACK_GUARD_EN
  function automatic bit overflow(input logic [2:0] o, input int sz);
    return (o == PUSH || o == DUP || o == OVER) && sz == D;
  endfunction
`endif

  task automatic apply_op(input logic [2:0] o, input logic [W-1:0] d);
    int           sz;
    logic [W-1:0] t, n;
    sz = stk.size();
    t  = m_t();
    n  = m_n();
    case (o)
      PUSH:  stk.push_back(d);
      DUP:   stk.push_back(t);
      OVER:  stk.push_back(n);
      POP:   void'(stk.pop_back());
      SWAP:  begin stk[sz-1] = n; stk[sz-2] = t; end
      BINOP: begin void'(stk.pop_back()); void'(stk.pop_back()); stk.push_back(d); end
      REPL:  stk[sz-1] = d;
      default: ;
    endcase
    while (stk.size() > D) stk.delete(0);
  endtask

  task automatic step(input bit rst, input bit v, input logic [2:0] o,
                      input logic [W-1:0] d, input string nm);
    exp_t e;
    @(negedge clock);
    reset = rst; op_valid = v; op = o; din = d;
    if (rst) begin
      stk.delete();
      merr = 1'b0;
    end else if (v && o != NOP) begin
`ifdef FORTH_STACK_GUARD_EN
      if (overflow(o, stk.size()) || underflow(o, stk.size())) merr = 1'b1;
      else apply_op(o, d);
`else
      apply_op(o, d);
`endif
    end
    e.nm = nm; e.tos = m_t(); e.nos = m_n(); e.depth = stk.size();
    e.empty = (stk.size() == 0); e.full = (stk.size() == D); e.error = merr;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input string f, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s.%s actual=%0h expected=%0h", nm, f, act, expv);
    end
  endtask

  // Monitor: every cycle's registered result is compared against the queued expectation.
  initial begin
    forever begin
      @(posedge clock);
      #2;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk(e.nm, "tos",   32'(tos),   32'(e.tos));
        chk(e.nm, "nos",   32'(nos),   32'(e.nos));
        chk(e.nm, "depth", 32'(depth), 32'(e.depth));
        chk(e.nm, "empty", 32'(empty), 32'(e.empty));
        chk(e.nm, "full",  32'(full),  32'(e.full));
        chk(e.nm, "error", 32'(error), 32'(e.error));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]   o;
    logic [W-1:0] d;
    bit           v, r;
    int           waitc;

    merr = 1'b0;
    step(1, 0, NOP, '0, "reset");
    step(0, 1, PUSH, 16'h1111, "push1");
    step(0, 1, PUSH, 16'h2222, "push2");
    step(0, 1, PUSH, 16'h3333, "push3");
    step(0, 1, SWAP, '0, "swap");
    step(0, 1, OVER, '0, "over");
    repeat (4) step(0, 1, POP, '0, "pop_to_empty");
    step(0, 1, PUSH, 16'd5, "push5");
    step(0, 1, PUSH, 16'd7, "push7");
    step(0, 1, BINOP, m_n() + m_t(), "binop_add");
    step(0, 0, BINOP, 16'hFFFF, "idle_invalid");

    step(1, 0, NOP, '0, "reset_ovf");
    step(0, 1, PUSH, 16'hA001, "fill1");
    step(0, 1, PUSH, 16'hA002, "fill2");
    step(0, 1, PUSH, 16'hA003, "fill3");
    step(0, 1, PUSH, 16'hA004, "fill4");
    step(0, 1, PUSH, 16'hA005, "push_full");
    step(0, 1, DUP, '0, "dup_full");
    repeat (4) step(0, 1, POP, '0, "drain");

`ifdef FORTH_STACK_GUARD_EN
    step(0, 1, POP, '0, "pop_empty");
    step(0, 1, SWAP, '0, "swap_empty");
    step(1, 0, NOP, '0, "reset_clears_err");
`endif

    step(0, 1, PUSH, 16'h0C01, "pre1");
    step(0, 1, PUSH, 16'h0C02, "pre2");
    step(1, 1, PUSH, 16'hBEEF, "reset_with_push");
    step(0, 1, PUSH, 16'h0D01, "after_reset");

    for (int i = 0; i < 600; i++) begin
      o = 3'($urandom_range(0, 7));
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 59) == 0);
      d = W'($urandom);
`ifndef FORTH_STACK_GUARD_EN
      if (v && underflow(o, stk.size())) o = PUSH;
`endif
      if (o == BINOP && $urandom_range(0, 1) == 1) d = m_n() + m_t();
      step(r, v, o, d, "random");
    end
    step(0, 0, NOP, '0, "final_idle");

    @(negedge clock);
    op_valid = 1'b0;
    waitc = 0;
    while (exp_q.size() > 0 && waitc < 20) begin
      @(negedge clock);
      waitc++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d expected=0 pending", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
